audio_dac_serializer: RTL and testbench

Output end of the stereo effects chain: accepts processed 32-bit signed L/R sample pairs from the effect modules (distortion et al.) through a valid/ready handshake, saturates them to the codec word width and shifts them out MSB-first to the audio codec DAC in I2S format. The codec is bus master: `AUD_BCLK` and `AUD_DACLRCK` are codec-driven inputs, synchronised into the `CLOCK_50` domain. One sample pair is consumed per LRCK frame, with underrun and clip reporting.

---
 rtl/audio_dac_serializer.sv | 125 ++++++++++++
 tb/tb_audio_dac_serializer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/audio_dac_serializer.sv
// audio_dac_serializer: buffers one stereo pair, saturates it to the codec width and shifts it out as I2S slave data.
`timescale 1ns/1ps
module audio_dac_serializer #(
    parameter int SAMPLE_BITS = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [31:0] in_L,
    input  logic [31:0] in_R,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        AUD_BCLK,
    input  logic        AUD_DACLRCK,
    output logic        AUD_DACDAT,
    output logic        underrun,
    output logic        clip
);
    typedef enum logic [1:0] {IDLE, DELAY, SHIFT, PAD} state_t;
    localparam int CW = $clog2(SAMPLE_BITS + 1);
    localparam logic [CW-1:0] LAST = CW'(SAMPLE_BITS);
    localparam logic signed [31:0] MAX_POS = 32'sh7fffffff >>> (32 - SAMPLE_BITS);
    localparam logic signed [31:0] MAX_NEG = ~MAX_POS;

    state_t state, state_nx;
    logic [SYNC_STAGES-1:0] bclk_sync, lrck_sync;
    logic bclk_hist, lrck_hist, bclk_fall, lrck_fall, lrck_rise;
    logic full, lr_edge, shift_en, clip_l, clip_r;
    logic signed [31:0] buf_l, buf_r;
    logic [SAMPLE_BITS-1:0] shreg, right_word, prev_l, prev_r, sat_l, sat_r;
    logic [CW-1:0] bit_cnt;

    function automatic logic [SAMPLE_BITS-1:0] sat(input logic signed [31:0] v);
        return v > MAX_POS ? MAX_POS[SAMPLE_BITS-1:0] : v < MAX_NEG ? MAX_NEG[SAMPLE_BITS-1:0] : v[SAMPLE_BITS-1:0];
    endfunction

    assign in_ready = !full;
    assign sat_l    = sat(buf_l);
    assign sat_r    = sat(buf_r);
    assign clip_l   = (buf_l > MAX_POS) || (buf_l < MAX_NEG);
    assign clip_r   = (buf_r > MAX_POS) || (buf_r < MAX_NEG);
    assign lr_edge  = lrck_fall || (lrck_rise && state != IDLE);
    assign shift_en = bclk_fall && (state == DELAY || (state == SHIFT && bit_cnt != LAST));

    // Edge pulses are registered so they line up SYNC_STAGES+1 cycles after the pin edge.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            bclk_sync <= '0;
            lrck_sync <= '0;
            bclk_hist <= 1'b0;
            lrck_hist <= 1'b0;
            bclk_fall <= 1'b0;
            lrck_fall <= 1'b0;
            lrck_rise <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], AUD_BCLK};
            lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], AUD_DACLRCK};
            bclk_hist <= bclk_sync[SYNC_STAGES-1];
            lrck_hist <= lrck_sync[SYNC_STAGES-1];
            bclk_fall <= bclk_hist && !bclk_sync[SYNC_STAGES-1];
            lrck_fall <= lrck_hist && !lrck_sync[SYNC_STAGES-1];
            lrck_rise <= !lrck_hist && lrck_sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // An LRCK edge outranks a coincident BCLK fall: that fall only opens the delay bit.
    always_comb begin
        state_nx = state;
        if (lr_edge)        state_nx = DELAY;
        else if (bclk_fall) state_nx = state == DELAY ? SHIFT : (state == SHIFT && bit_cnt == LAST) ? PAD : state;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            full       <= 1'b0;
            buf_l      <= '0;
            buf_r      <= '0;
            shreg      <= '0;
            right_word <= '0;
            prev_l     <= '0;
            prev_r     <= '0;
            bit_cnt    <= '0;
            AUD_DACDAT <= 1'b0;
            underrun   <= 1'b0;
            clip       <= 1'b0;
        end else begin
            underrun <= 1'b0;
            clip     <= 1'b0;
            if (in_valid && !full) begin
                full  <= 1'b1;
                buf_l <= in_L;
                buf_r <= in_R;
            end
            if (lr_edge) begin
                AUD_DACDAT <= 1'b0;
                bit_cnt    <= '0;
                if (lrck_fall && full) begin
                    shreg      <= sat_l;
                    right_word <= sat_r;
                    prev_l     <= sat_l;
                    prev_r     <= sat_r;
                    full       <= 1'b0;
                    clip       <= clip_l || clip_r;
                end else if (lrck_fall) begin
                    shreg      <= prev_l;
                    right_word <= prev_r;
                    underrun   <= 1'b1;
                end else begin
                    shreg <= right_word;
                end
            end else if (shift_en) begin
                AUD_DACDAT <= shreg[SAMPLE_BITS-1];
                shreg      <= {shreg[SAMPLE_BITS-2:0], 1'b0};
                bit_cnt    <= bit_cnt + 1'b1;
            end else if (bclk_fall && state == SHIFT) begin
                AUD_DACDAT <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_audio_dac_serializer.sv
// tb_audio_dac_serializer: drives codec-style BCLK/LRCK frames and checks the serial words against a queue-based model.
`timescale 1ns/1ps
module tb_audio_dac_serializer;
    localparam int SB = 24;
    localparam int HALF = 163;

    logic CLOCK_50 = 1'b0, reset = 1'b1;
    logic [31:0] in_L = '0, in_R = '0;
    logic in_valid = 1'b0, in_ready, AUD_BCLK = 1'b1, AUD_DACLRCK = 1'b1, AUD_DACDAT, underrun, clip;
    int n_cmp = 0, n_bad = 0, n_und = 0, n_clip = 0;
    logic [31:0] acc_l[$], acc_r[$];
    logic [63:0] prev_l = '0, prev_r = '0;

    always #10 CLOCK_50 = ~CLOCK_50;

    audio_dac_serializer dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .in_L(in_L), .in_R(in_R), .in_valid(in_valid),
        .in_ready(in_ready), .AUD_BCLK(AUD_BCLK), .AUD_DACLRCK(AUD_DACLRCK),
        .AUD_DACDAT(AUD_DACDAT), .underrun(underrun), .clip(clip)
    );

    always @(posedge CLOCK_50) if (in_valid && in_ready) begin
        acc_l.push_back(in_L);
        acc_r.push_back(in_R);
    end

    always @(negedge CLOCK_50) begin
        if (underrun) n_und++;
        if (clip) n_clip++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] sat(input logic [31:0] v);
        longint s = longint'($signed(v));
        longint mx = (longint'(1) <<< (SB - 1)) - 1;
        if (s > mx) return 64'(mx);
        if (s < -mx - 1) return 64'(longint'(1) <<< (SB - 1));
        return 64'(s & ((longint'(1) <<< SB) - 1));
    endfunction

    function automatic bit clipped(input logic [31:0] v);
        longint s = longint'($signed(v));
        longint mx = (longint'(1) <<< (SB - 1)) - 1;
        return s > mx || s < -mx - 1;
    endfunction

    task automatic offer(input logic [31:0] l, input logic [31:0] r);
        bit done = 0;
        @(negedge CLOCK_50);
        in_L = l;
        in_R = r;
        in_valid = 1'b1;
        for (int c = 0; c < 5000 && !done; c++) begin
            if (in_ready) begin
                @(posedge CLOCK_50);
                done = 1;
            end
            @(negedge CLOCK_50);
        end
        in_valid = 1'b0;
        if (!done) check("accept_timeout", 0, 1);
    endtask

    task automatic run_frame(input int s, input int rst_at);
        logic [63:0] got_l = '0, got_r = '0, exp_l = '0, exp_r = '0, wl, wr;
        bit ld = 0, ex_clip = 0;
        n_und = 0;
        n_clip = 0;
        if (acc_l.size() > 0) begin
            ld = 1;
            ex_clip = clipped(acc_l[0]) || clipped(acc_r[0]);
            prev_l = sat(acc_l.pop_front());
            prev_r = sat(acc_r.pop_front());
        end
        wl = prev_l;
        wr = prev_r;
        for (int i = 0; i < 2 * s; i++) begin
            AUD_BCLK = 1'b0;
            if (i == 0) AUD_DACLRCK = 1'b0;
            if (i == s) AUD_DACLRCK = 1'b1;
            if (i == rst_at) begin
                #120;
                reset = 1'b1;
                #1;
                check("dat_in_reset", AUD_DACDAT, 0);
                #100;
                reset = 1'b0;
                AUD_BCLK = 1'b1;
                AUD_DACLRCK = 1'b1;
                prev_l = '0;
                prev_r = '0;
                acc_l.delete();
                acc_r.delete();
                #300;
                check("ready_after_reset", in_ready, 1);
                return;
            end
            #HALF;
            AUD_BCLK = 1'b1;
            if (i % s != 0) begin
                if (i < s) got_l = {got_l[62:0], AUD_DACDAT};
                else       got_r = {got_r[62:0], AUD_DACDAT};
            end
            #HALF;
        end
        for (int p = 1; p < s; p++) begin
            exp_l = {exp_l[62:0], p <= SB ? wl[SB-p] : 1'b0};
            exp_r = {exp_r[62:0], p <= SB ? wr[SB-p] : 1'b0};
        end
        #200;
        check("left_slot", got_l, exp_l);
        check("right_slot", got_r, exp_r);
        check("underrun_pulses", 64'(n_und), 64'(!ld));
        check("clip_pulses", 64'(n_clip), 64'(ld && ex_clip));
    endtask

    initial begin
        logic [31:0] bl[4] = '{32'h007FFFFF, 32'h00800000, 32'hFF800000, 32'hFF7FFFFF};
        #200;
        check("rst_ready", in_ready, 1);
        check("rst_dat", AUD_DACDAT, 0);
        check("rst_underrun", underrun, 0);
        check("rst_clip", clip, 0);
        reset = 1'b0;
        #500;
        offer(32'h00123456, 32'hFFEDCBAA);
        check("ready_after_accept", in_ready, 0);
        run_frame(32, -1);
        offer(32'sd45000000, -32'sd45000000);
        run_frame(32, -1);
        run_frame(32, -1);
        check("ready_on_replay", in_ready, 1);
        run_frame(32, -1);
        offer(32'h00ABCDEF, 32'h00000001);
        fork
            offer(32'hFF000123, 32'h00654321);
            run_frame(32, -1);
        join
        check("second_held", in_ready, 0);
        run_frame(32, -1);
        for (int k = 0; k < 4; k += 2) begin
            offer(bl[k], bl[k+1]);
            run_frame(32, -1);
        end
        offer(bl[0], bl[2]);
        run_frame(32, -1);
        offer(32'h00C0FFEE, 32'hFF3A5A5A);
        run_frame(16, -1);
        run_frame(16, -1);
        for (int k = 0; k < 8; k++) begin
            logic [31:0] l = $urandom, r = $urandom;
            if ($urandom_range(1, 0) == 1) l = $signed(l) >>> 8;
            if ($urandom_range(1, 0) == 1) r = $signed(r) >>> 8;
            if ($urandom_range(3, 0) != 0) offer(l, r);
            run_frame(($urandom_range(1, 0) == 1) ? 32 : 20, -1);
        end
        offer(32'h00FFFFFF, 32'h00123456);
        run_frame(32, 10);
        run_frame(32, -1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
